// File: rtl/mem_responder.sv
// Word-addressed 32-bit scratchpad that answers the accelerator memory protocol.
// The host port may access the array only while the responder is idle and no request is present.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no request in flight; host port may access the array
// ST_WAIT | request latched, counting down the configured latency
// ST_DONE | completion cycle: opdone pulse, read data or write commit
// ST_HOLD | initiator still asserts the completed request; await change
module mem_responder #(
    parameter int DEPTH   = 256,
    parameter int AW      = 8,
    parameter int LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    mem_operation,
    input  logic [31:0]   addr_i,
    input  logic [31:0]   data_i,
    output logic [31:0]   data_o,
    output logic          mem_opdone,
    output logic          mem_err,
    input  logic          host_en,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [31:0]   host_wdata,
    output logic [31:0]   host_rdata,
    output logic          host_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Counter holds the remaining WAIT cycles minus one, so DONE lands LATENCY cycles after acceptance.
    localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   data_hold_q;
    logic [31:0]   host_rdata_q;

    logic [31:0]   mem_q [0:DEPTH-1];

    logic          req_valid;
    logic          req_new;
    logic          accept;
    logic          out_of_range;
    logic          is_write;
    logic [31:0]   rd_word;
    logic          host_acc;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    // 2'b10 is reserved and behaves exactly like no request.
    assign req_valid    = (mem_operation == 2'b01) || (mem_operation == 2'b11);
    assign req_new      = req_valid && ((addr_i != addr_q) || (mem_operation != op_q));
    assign out_of_range = (addr_q >= 32'(DEPTH));
    assign is_write     = op_q[1];
    assign rd_word      = out_of_range ? 32'd0 : mem_q[addr_q[AW-1:0]];

    assign host_ready = (state_q == ST_IDLE) && !req_valid;
    assign host_acc   = host_en && host_ready;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (req_new) begin
                    accept = 1'b1;
                end else if (!req_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            op_d    = mem_operation;
            addr_d  = addr_i;
            wdata_d = data_i;
            cnt_d   = CNT_LOAD;
            state_d = (LATENCY == 0) ? ST_DONE : ST_WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= 2'b00;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            cnt_q        <= 4'd0;
            data_hold_q  <= 32'd0;
            host_rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            if ((state_q == ST_DONE) && !is_write) begin
                data_hold_q <= rd_word;
            end
            if (host_acc && !host_we) begin
                host_rdata_q <= mem_q[host_addr];
            end
        end
    end

    // Initiator writes happen only in DONE and host access only in IDLE, so they never collide.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = host_addr;
        mem_wdata = host_wdata;
        if ((state_q == ST_DONE) && is_write && !out_of_range) begin
            mem_we    = 1'b1;
            mem_waddr = addr_q[AW-1:0];
            mem_wdata = wdata_q;
        end else if (host_acc && host_we) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign data_o     = ((state_q == ST_DONE) && !is_write) ? rd_word : data_hold_q;
    assign mem_opdone = (state_q == ST_DONE);
    assign mem_err    = (state_q == ST_DONE) && out_of_range;
    assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances at LATENCY 1, 0 and 5.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_mem_responder;

    localparam int I_L1 = 0;
    localparam int I_L0 = 1;
    localparam int I_L5 = 2;

    logic        clk;
    logic        reset      [3];
    logic [1:0]  op         [3];
    logic [31:0] addr       [3];
    logic [31:0] wdata      [3];
    logic [31:0] rdata      [3];
    logic        done       [3];
    logic        err        [3];
    logic        hen        [3];
    logic        hwe        [3];
    logic [7:0]  haddr      [3];
    logic [31:0] hwd        [3];
    logic [31:0] hrd        [3];
    logic        hrdy       [3];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 5);
        mem_responder #(
            .DEPTH  (256),
            .AW     (8),
            .LATENCY(LAT)
        ) u_dut (
            .clk          (clk),
            .reset        (reset[g]),
            .mem_operation(op[g]),
            .addr_i       (addr[g]),
            .data_i       (wdata[g]),
            .data_o       (rdata[g]),
            .mem_opdone   (done[g]),
            .mem_err      (err[g]),
            .host_en      (hen[g]),
            .host_we      (hwe[g]),
            .host_addr    (haddr[g]),
            .host_wdata   (hwd[g]),
            .host_rdata   (hrd[g]),
            .host_ready   (hrdy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input int g, input logic [7:0] a, input logic [31:0] d);
        hen[g] = 1'b1; hwe[g] = 1'b1; haddr[g] = a; hwd[g] = d;
        tick();
        hen[g] = 1'b0; hwe[g] = 1'b0;
    endtask

    task automatic host_rd(input int g, input logic [7:0] a, output logic [31:0] d);
        hen[g] = 1'b1; hwe[g] = 1'b0; haddr[g] = a;
        tick();
        hen[g] = 1'b0;
        d = hrd[g];
    endtask

    // Returns with the bench positioned inside the opdone cycle; n is the cycles waited.
    task automatic wait_done(input int g, input int lim, input string tag, output int n);
        n = 0;
        while (n < lim && done[g] !== 1'b1) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, done[g]}, 32'd1);
    endtask

    logic [31:0] exp_burst [5];
    logic [31:0] v;
    int pulses;
    int last;
    int n;

    initial begin
        exp_burst = '{32'd3, 32'd3, 32'd2, 32'd2, 32'h44};
        for (int g = 0; g < 3; g++) begin
            reset[g] = 1'b1; op[g] = 2'b00; addr[g] = '0; wdata[g] = '0;
            hen[g] = 1'b0; hwe[g] = 1'b0; haddr[g] = '0; hwd[g] = '0;
        end
        repeat (3) tick();
        for (int g = 0; g < 3; g++) reset[g] = 1'b0;
        tick();

        chk("rst_data_o", rdata[I_L1], 32'd0);
        chk("rst_opdone", {31'd0, done[I_L1]}, 32'd0);
        chk("rst_err", {31'd0, err[I_L1]}, 32'd0);
        chk("rst_host_rdata", hrd[I_L1], 32'd0);
        chk("rst_host_ready", {31'd0, hrdy[I_L1]}, 32'd1);

        // Preload through the host port.
        host_wr(I_L1, 8'd0, 32'd3);
        host_wr(I_L1, 8'd1, 32'd3);
        host_wr(I_L1, 8'd2, 32'd2);
        host_wr(I_L1, 8'd3, 32'd2);
        host_wr(I_L1, 8'd4, 32'h44);
        host_wr(I_L1, 8'd20, 32'h11);
        host_wr(I_L1, 8'hFF, 32'h1234_5678);
        host_rd(I_L1, 8'd2, v);
        chk("host_rd_preload", v, 32'd2);

        // Parameter-fetch burst: op held at read, address stepped after each opdone.
        op[I_L1] = 2'b01; addr[I_L1] = 32'd0;
        pulses = 0; last = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done[I_L1]) begin
                if (pulses < 5) chk("burst_data", rdata[I_L1], exp_burst[pulses]);
                chk("burst_err", {31'd0, err[I_L1]}, 32'd0);
                if (pulses == 0) chk("burst_first_latency", c, 32'd1);
                else chk("burst_spacing", c - last, 32'd3);
                last = c;
                pulses++;
                if (addr[I_L1] < 32'd4) addr[I_L1] = addr[I_L1] + 32'd1;
            end
        end
        chk("burst_pulses", pulses, 32'd5);
        op[I_L1] = 2'b00;
        tick(); tick();

        // Held request must fire exactly once.
        op[I_L1] = 2'b01; addr[I_L1] = 32'd5;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done[I_L1]) pulses++;
        end
        chk("held_pulses", pulses, 32'd1);
        addr[I_L1] = 32'd6;
        wait_done(I_L1, 6, "held_step_done", n);
        chk("held_step_latency", n, 32'd2);
        op[I_L1] = 2'b00;
        tick(); tick();

        // Host contention: initiator wins, host write is dropped.
        op[I_L1] = 2'b01; addr[I_L1] = 32'd20;
        hen[I_L1] = 1'b1; hwe[I_L1] = 1'b1; haddr[I_L1] = 8'd20; hwd[I_L1] = 32'hAAAA_5555;
        #1;
        chk("contend_ready", {31'd0, hrdy[I_L1]}, 32'd0);
        tick();
        hen[I_L1] = 1'b0; hwe[I_L1] = 1'b0;
        wait_done(I_L1, 4, "contend_done", n);
        chk("contend_rd_old", rdata[I_L1], 32'h11);
        op[I_L1] = 2'b00;
        tick(); tick();
        chk("data_o_hold", rdata[I_L1], 32'h11);
        hen[I_L1] = 1'b1; hwe[I_L1] = 1'b1; haddr[I_L1] = 8'd20; hwd[I_L1] = 32'hAAAA_5555;
        #1;
        chk("retry_ready", {31'd0, hrdy[I_L1]}, 32'd1);
        tick();
        hen[I_L1] = 1'b0; hwe[I_L1] = 1'b0;
        host_rd(I_L1, 8'd20, v);
        chk("retry_written", v, 32'hAAAA_5555);

        // Out of range read and write.
        op[I_L1] = 2'b01; addr[I_L1] = 32'h100;
        wait_done(I_L1, 4, "oor_rd_done", n);
        chk("oor_rd_err", {31'd0, err[I_L1]}, 32'd1);
        chk("oor_rd_data", rdata[I_L1], 32'd0);
        op[I_L1] = 2'b00;
        tick(); tick();
        op[I_L1] = 2'b11; addr[I_L1] = 32'h1FF; wdata[I_L1] = 32'hCAFE_F00D;
        wait_done(I_L1, 4, "oor_wr_done", n);
        chk("oor_wr_err", {31'd0, err[I_L1]}, 32'd1);
        op[I_L1] = 2'b00;
        tick(); tick();
        host_rd(I_L1, 8'hFF, v);
        chk("oor_wr_dropped", v, 32'h1234_5678);

        // LATENCY=0: write then read back.
        op[I_L0] = 2'b11; addr[I_L0] = 32'd10; wdata[I_L0] = 32'hDEAD_BEEF;
        tick();
        chk("l0_wr_done", {31'd0, done[I_L0]}, 32'd1);
        chk("l0_wr_err", {31'd0, err[I_L0]}, 32'd0);
        op[I_L0] = 2'b00;
        tick(); tick();
        op[I_L0] = 2'b01; addr[I_L0] = 32'd10;
        tick();
        chk("l0_rd_done", {31'd0, done[I_L0]}, 32'd1);
        chk("l0_rd_data", rdata[I_L0], 32'hDEAD_BEEF);
        op[I_L0] = 2'b00;
        tick(); tick();
        host_rd(I_L0, 8'd10, v);
        chk("l0_host_rd", v, 32'hDEAD_BEEF);

        // LATENCY=5: read for latency, then a write aborted by reset.
        host_wr(I_L5, 8'd7, 32'h77);
        op[I_L5] = 2'b01; addr[I_L5] = 32'd7;
        wait_done(I_L5, 10, "l5_rd_done", n);
        chk("l5_rd_latency", n, 32'd6);
        chk("l5_rd_data", rdata[I_L5], 32'h77);
        op[I_L5] = 2'b00;
        tick(); tick();
        host_rd(I_L5, 8'd7, v);
        chk("l5_host_rd", v, 32'h77);
        op[I_L5] = 2'b11; addr[I_L5] = 32'd7; wdata[I_L5] = 32'hBAD0_BAD0;
        pulses = 0;
        tick(); if (done[I_L5]) pulses++;
        tick(); if (done[I_L5]) pulses++;
        reset[I_L5] = 1'b1; op[I_L5] = 2'b00;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done[I_L5]) pulses++;
        end
        reset[I_L5] = 1'b0;
        tick();
        chk("abort_no_opdone", pulses, 32'd0);
        chk("abort_data_o", rdata[I_L5], 32'd0);
        chk("abort_opdone", {31'd0, done[I_L5]}, 32'd0);
        chk("abort_err", {31'd0, err[I_L5]}, 32'd0);
        chk("abort_host_rdata", hrd[I_L5], 32'd0);
        chk("abort_host_ready", {31'd0, hrdy[I_L5]}, 32'd1);
        host_rd(I_L5, 8'd7, v);
        chk("abort_mem_kept", v, 32'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
